flow_bus_elastic_pipe: RTL and testbench

Parametrised, fully registered ready/valid pipeline for the flow bus. It is built from a chain of STAGES two-entry elastic (skid) stages and sustains one transfer per cycle with no combinational path from down_ready to up_ready. It adds global stall (enable), synchronous flush, and an occupancy count. It sits between flow-bus producers and consumers wherever timing must be cut on both the data path and the ready path.

---
 rtl/flow_bus_elastic_pipe.sv | 161 ++++++++++++++++
 tb/tb_flow_bus_elastic_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_bus_elastic_pipe.sv
// flow_bus_elastic_pipe: chain of STAGES two-entry elastic stages.
// Every output is driven from a flop, gated only by enable, flush and rst.
// This cuts timing on both the data path and the ready path.
//
// Handshake: a word moves across a port exactly when valid and ready are
// both high at a rising clk edge. A producer may drive valid before it
// sees ready. Ready never depends on valid or ready from further
// downstream in the same cycle. down_data always holds the oldest stored
// word while down_valid is high.
module flow_bus_elastic_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2,
  parameter bit USE_ENABLE = 1'b1,
  localparam int OCC_WIDTH = $clog2(2*STAGES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  up_ready,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  down_ready,
  output logic                  down_valid,
  output logic [DATA_WIDTH-1:0] down_data,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  localparam logic [OCC_WIDTH-1:0] OCC_ONE = OCC_WIDTH'(1);

  // Per-stage state exported so neighbouring stages can see it.
  logic [STAGES-1:0]     m_valid_v;
  logic [STAGES-1:0]     rdy_v;
  logic [DATA_WIDTH-1:0] m_data_v [STAGES];

  logic en_eff;
  logic active;
  logic up_fire;
  logic down_fire;

  // With USE_ENABLE cleared, enable is forced high.
  assign en_eff = enable | ~USE_ENABLE;
  // No handshake may complete while frozen or flushing.
  assign active = en_eff & ~flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_ready;
    logic                  in_fire;
    logic                  out_fire;

    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
    logic                  s_valid_q, s_valid_d;
    logic [DATA_WIDTH-1:0] s_data_q,  s_data_d;
    logic                  rdy_q,     rdy_d;

    if (g == 0) begin : g_first
      assign in_valid = up_valid;
      assign in_data  = up_data;
      assign up_fire  = in_fire;
    end else begin : g_chain
      assign in_valid = m_valid_v[g-1];
      assign in_data  = m_data_v[g-1];
    end

    if (g == STAGES-1) begin : g_last
      assign out_ready = down_ready;
      assign down_fire = out_fire;
    end else begin : g_inner
      assign out_ready = rdy_v[g+1];
    end

    assign in_fire  = in_valid & rdy_q & active;
    assign out_fire = m_valid_q & out_ready & active;

    assign m_valid_v[g] = m_valid_q;
    assign m_data_v[g]  = m_data_q;
    assign rdy_v[g]     = rdy_q;

    // Next state of the M/S pair: S refills M first, so the order is kept.
    always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (out_fire) begin
        if (s_valid_q) begin
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else if (in_fire) begin
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
        end
      end
      if (flush) begin
        m_valid_d = 1'b0;
        s_valid_d = 1'b0;
      end
      // Ready is the registered emptiness of the skid slot.
      rdy_d = ~s_valid_d;
    end

    // Stage registers; reset leaves the stage empty and ready.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_valid_q <= 1'b0;
        m_data_q  <= '0;
        s_valid_q <= 1'b0;
        s_data_q  <= '0;
        rdy_q     <= 1'b1;
      end else begin
        m_valid_q <= m_valid_d;
        m_data_q  <= m_data_d;
        s_valid_q <= s_valid_d;
        s_data_q  <= s_data_d;
        rdy_q     <= rdy_d;
      end
    end
  end

  logic [OCC_WIDTH-1:0] occ_q, occ_d;

  // Word count: up adds one, down removes one, both together cancel.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (up_fire && !down_fire) begin
      occ_d = occ_q + OCC_ONE;
    end else if (down_fire && !up_fire) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // The stage-0 ready flop resets to 1, so up_ready is also masked by rst.
  assign up_ready   = rdy_v[0] & active & rst;
  assign down_valid = m_valid_v[STAGES-1] & active;
  assign down_data  = m_data_v[STAGES-1];
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_flow_bus_elastic_pipe.sv
// Bench for flow_bus_elastic_pipe. Three instances (STAGES = 2, 1, 8) share
// one stimulus. Directed phases target the STAGES=2 instance. A per-instance
// FIFO model checks order, occupancy and the gating rules on every cycle.
module tb_flow_bus_elastic_pipe;

  localparam int DW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic flush;
  logic up_valid;
  logic [DW-1:0] up_data;
  logic down_ready;

  logic [NI-1:0] up_ready_v;
  logic [NI-1:0] down_valid_v;
  logic [DW-1:0] down_data_v [NI];
  logic [7:0]    occ_v [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int ST  = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    localparam int CAP = 2*ST;
    localparam int OW  = $clog2(2*ST+1);

    logic [OW-1:0] occ;
    logic [DW-1:0] exp_q[$];

    flow_bus_elastic_pipe #(
      .DATA_WIDTH(DW),
      .STAGES    (ST),
      .USE_ENABLE(1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .flush     (flush),
      .up_ready  (up_ready_v[g]),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .down_ready(down_ready),
      .down_valid(down_valid_v[g]),
      .down_data (down_data_v[g]),
      .occupancy (occ)
    );

    assign occ_v[g] = 8'(occ);

    // scoreboard monitor: a FIFO of accepted words
    always @(negedge clk) begin
      if (!rst) begin
        exp_q.delete();
      end else begin
        if (flush || !enable) begin
          check($sformatf("s%0d_gate_up_ready", ST), up_ready_v[g], 0);
          check($sformatf("s%0d_gate_down_valid", ST), down_valid_v[g], 0);
        end
        check($sformatf("s%0d_occ_eq_model", ST), occ, exp_q.size());
        check($sformatf("s%0d_occ_le_cap", ST), occ <= CAP, 1);
        if (down_valid_v[g]) begin
          check($sformatf("s%0d_out_nonempty", ST), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check($sformatf("s%0d_out_data", ST), down_data_v[g], exp_q[0]);
            if (down_ready) void'(exp_q.pop_front());
          end
        end
        if (flush) exp_q.delete();
        else if (up_valid && up_ready_v[g]) exp_q.push_back(up_data);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    up_valid   = 1'b0;
    down_ready = 1'b1;
    enable     = 1'b1;
    flush      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push3(input logic [DW-1:0] base);
    int   n;
    logic took;
    n = 0;
    down_ready = 1'b0;
    up_valid   = 1'b1;
    up_data    = base;
    for (int t = 0; t < 10 && n < 3; t++) begin
      @(negedge clk);
      took = up_ready_v[0];
      tick();
      if (took) begin
        n++;
        up_data = base + 8'(n);
      end
    end
    check("push3_count", n, 3);
  endtask

  logic [DW-1:0] d;
  logic [7:0]    occ_hold;
  logic          took;
  int            acc;
  int            pct;

  initial begin
    rst = 1'b0; enable = 1'b1; flush = 1'b0;
    up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rel_up_ready", up_ready_v[0], 1);
    check("rel_occ", occ_v[0], 0);
    check("rel_down_valid", down_valid_v[0], 0);

    // streaming 0..14 at full rate
    down_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      up_valid = (c < 15);
      up_data  = 8'(c);
      @(negedge clk);
      if (c < 15) check("stream_up_ready", up_ready_v[0], 1);
      if (c >= 2 && c < 17) begin
        check("stream_down_valid", down_valid_v[0], 1);
        check("stream_down_data", down_data_v[0], c - 2);
      end else begin
        check("stream_down_idle", down_valid_v[0], 0);
      end
      check("stream_occ_le2", occ_v[0] <= 2, 1);
    end
    drain(40);

    // backpressure: exactly four words fit
    d = 8'd1; acc = 0;
    up_valid = 1'b1; up_data = d; down_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      took = up_ready_v[0];
      tick();
      if (took) begin acc++; d++; up_data = d; end
    end
    check("bp_accepted", acc, 4);
    @(negedge clk);
    check("bp_up_ready", up_ready_v[0], 0);
    check("bp_occ", occ_v[0], 4);
    tick();
    down_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("bp_down_valid", down_valid_v[0], 1);
      check("bp_down_data", down_data_v[0], j + 1);
      took = up_ready_v[0];
      tick();
      if (took) begin d++; up_data = d; end
    end

    // enable low for four cycles mid-stream
    for (int t = 0; t < 14; t++) begin
      enable = !(t >= 4 && t < 8);
      @(negedge clk);
      if (t == 4) occ_hold = occ_v[0];
      if (t > 4 && t <= 8) check("en_occ_hold", occ_v[0], occ_hold);
      took = up_ready_v[0];
      tick();
      if (took) begin d++; up_data = d; end
    end
    enable = 1'b1;
    drain(40);

    // flush with three words held
    push3(8'h10);
    flush = 1'b1; up_valid = 1'b1; up_data = 8'h77;
    @(negedge clk);
    check("fl_occ_before", occ_v[0], 3);
    check("fl_up_ready", up_ready_v[0], 0);
    tick();
    flush = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    check("fl_occ_after", occ_v[0], 0);
    check("fl_down_valid", down_valid_v[0], 0);
    tick();
    up_valid = 1'b1; up_data = 8'hA5; down_ready = 1'b1;
    @(negedge clk);
    check("fl_a5_accept", up_ready_v[0], 1);
    tick();
    up_valid = 1'b0;
    @(negedge clk);
    check("fl_a5_not_yet", down_valid_v[0], 0);
    tick();
    @(negedge clk);
    check("fl_a5_valid", down_valid_v[0], 1);
    check("fl_a5_data", down_data_v[0], 8'hA5);
    drain(40);

    // asynchronous reset mid-stream
    push3(8'h31);
    up_valid = 1'b0;
    #1 check("rst_pre_valid", down_valid_v[0], 1);
    #1 rst = 1'b0;
    #1;
    check("rst_down_valid", down_valid_v[0], 0);
    check("rst_down_data", down_data_v[0], 0);
    check("rst_up_ready", up_ready_v[0], 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_rel_up_ready", up_ready_v[0], 1);
    check("rst_rel_occ", occ_v[0], 0);
    tick();

    // random traffic on all three instances
    for (int t = 0; t < 1000; t++) begin
      pct        = (t < 300) ? 80 : ((t < 600) ? 30 : 60);
      up_valid   = ($urandom_range(0, 3) != 0);
      down_ready = ($urandom_range(0, 99) < pct);
      enable     = ($urandom_range(0, 7) != 0);
      up_data    = 8'($urandom_range(0, 255));
      tick();
    end
    drain(60);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("final_occ_%0d", i), occ_v[i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
